// File: rtl/axi_pkg.sv
// Shared constants and types for the AXI4 write responder.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_e;

    // WRAP and the reserved encoding are rejected, as is any beat size other than full width.
    function automatic logic aw_is_err(input logic [1:0] burst,
                                       input logic [2:0] size,
                                       input logic [2:0] beat_size);
        return (burst == BURST_WRAP) || (burst == 2'b11) || (size != beat_size);
    endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Word-address generator: holds the burst start word and burst type, steps once per beat.
import axi_pkg::*;

module axi_wr_addr_gen #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [MEM_AW-1:0] i_addr,
    input  logic [1:0]        i_burst,
    input  logic              i_step,
    output logic [MEM_AW-1:0] o_addr
);

    logic [MEM_AW-1:0] r_addr;
    logic [1:0]        r_burst;

    // INCR wraps naturally at 2^MEM_AW; every other burst type holds the address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_burst <= BURST_FIXED;
        end else if (i_load) begin
            r_addr  <= i_addr;
            r_burst <= i_burst;
        end else if (i_step && (r_burst == BURST_INCR)) begin
            r_addr  <= r_addr + MEM_AW'(1);
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/axi_wr_resp.sv
// AXI4 write-channel responder: one burst at a time, one SRAM write per accepted W beat.
// Optional macro AXI_WR_RESP_WLAST_CHK_EN flags bursts whose s_wlast disagrees with the beat count.
import axi_pkg::*;

module axi_wr_resp #(
    parameter int AW     = 32,
    parameter int DW     = 64,
    parameter int IDW    = 4,
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDW-1:0]    s_awid,
    input  logic [AW-1:0]     s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic [1:0]        s_awburst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DW-1:0]     s_wdata,
    input  logic [DW/8-1:0]   s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [IDW-1:0]    s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wstrb
);

    localparam int         SHIFT     = $clog2(DW/8);
    localparam logic [2:0] BEAT_SIZE = 3'(SHIFT);

    wr_state_e         r_state;
    wr_state_e         w_next;
    logic [IDW-1:0]    r_id;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_last_beat;
    logic              w_wlast_bad;
    logic [MEM_AW-1:0] w_word;
    logic [MEM_AW-1:0] w_cur_addr;
    logic              w_unused;

    assign w_word      = s_awaddr[SHIFT +: MEM_AW];
    assign w_last_beat = (r_cnt == r_len);

    assign s_awready = ~rst & (r_state == ST_IDLE);
    assign s_wready  = ~rst & (r_state == ST_DATA);
    assign s_bvalid  = ~rst & (r_state == ST_RESP);
    assign s_bid     = r_id;
    assign s_bresp   = r_err ? RESP_SLVERR : RESP_OKAY;

    assign w_aw_hs = s_awvalid & s_awready;
    assign w_w_hs  = s_wvalid & s_wready;
    assign w_b_hs  = s_bvalid & s_bready;

`ifdef AXI_WR_RESP_WLAST_CHK_EN
    // The offending beat itself is suppressed along with the rest of the burst.
    assign w_wlast_bad = s_wlast != w_last_beat;
    assign w_unused    = ^{s_awaddr};
`else
    assign w_wlast_bad = 1'b0;
    assign w_unused    = ^{s_awaddr, s_wlast};
`endif

    // Memory port is combinational off the W handshake so the write lands in the beat's cycle.
    assign mem_we    = w_w_hs & ~r_err & ~w_wlast_bad;
    assign mem_addr  = w_cur_addr;
    assign mem_wdata = s_wdata;
    assign mem_wstrb = s_wstrb;

    axi_wr_addr_gen #(
        .MEM_AW (MEM_AW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_aw_hs),
        .i_addr  (w_word),
        .i_burst (s_awburst),
        .i_step  (w_w_hs),
        .o_addr  (w_cur_addr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_aw_hs) begin
                    w_next = ST_DATA;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_w_hs && w_last_beat) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_RESP: begin
                if (w_b_hs) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Burst context: ID, length, beat counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id  <= '0;
            r_len <= 8'd0;
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_id  <= s_awid;
            r_len <= s_awlen;
            r_cnt <= 8'd0;
            r_err <= aw_is_err(s_awburst, s_awsize, BEAT_SIZE);
        end else if (w_w_hs) begin
            r_cnt <= r_cnt + 8'd1;
            r_err <= r_err | w_wlast_bad;
        end
    end

endmodule

// File: tb/tb_axi_wr_resp.sv
// Self-checking bench for axi_wr_resp: directed plan steps plus randomized bursts vs a reference model.
module tb_axi_wr_resp;

    localparam int AW     = 32;
    localparam int DW     = 64;
    localparam int IDW    = 4;
    localparam int MEM_AW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic [IDW-1:0]    s_awid;
    logic [AW-1:0]     s_awaddr;
    logic [7:0]        s_awlen;
    logic [2:0]        s_awsize;
    logic [1:0]        s_awburst;
    logic              s_awvalid;
    logic              s_awready;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_wstrb;
    logic              s_wlast;
    logic              s_wvalid;
    logic              s_wready;
    logic [IDW-1:0]    s_bid;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;

    typedef struct {
        logic [11:0] a;
        logic [63:0] d;
        logic [7:0]  s;
    } wr_t;

    wr_t wr_q[$];
    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    axi_wr_resp #(.AW(AW), .DW(DW), .IDW(IDW), .MEM_AW(MEM_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_awid    (s_awid),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awsize  (s_awsize),
        .s_awburst (s_awburst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb)
    );

    // Memory-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back('{mem_addr, mem_wdata, mem_wstrb});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int bdelay,
                            input int wlast_idx, input int abort_at, input bit full_strb,
                            input bit gaps);
        logic [63:0] d[256];
        logic [7:0]  st[256];
        int          word;
        int          nb;
        bit          err;
        bit          ok;
        logic [1:0]  eresp;

        nb = (abort_at >= 0) ? abort_at : len + 1;
        for (int i = 0; i <= len; i++) begin
            d[i]  = {$urandom, $urandom};
            st[i] = full_strb ? 8'hFF : 8'($urandom);
        end

        // Reference model: error if WRAP/reserved or non-full-width beats, words from byte address.
        err  = (burst >= 2'd2) || (size != 3'd3);
        word = int'((addr >> 3) & 32'hFFF);
        exp_q.delete();
        wr_q.delete();
        for (int i = 0; i < nb; i++) begin
`ifdef AXI_WR_RESP_WLAST_CHK_EN
            if ((i == wlast_idx) != (i == len)) err = 1'b1;
`endif
            if (!err) exp_q.push_back('{12'(word), d[i], st[i]});
            if (burst == 2'b01) word = (word + 1) % 4096;
        end
        eresp = err ? 2'b10 : 2'b00;

        s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awsize = size; s_awburst = burst;
        s_awvalid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (s_awready === 1'b1) begin ok = 1'b1; break; end
        end
        check("aw_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
        @(negedge clk);
        check("w_ready_latency", 64'(s_wready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < nb; i++) begin
            if (gaps) begin
                s_wvalid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            s_wvalid = 1'b1; s_wdata = d[i]; s_wstrb = st[i]; s_wlast = (i == wlast_idx);
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (s_wready === 1'b1) begin ok = 1'b1; break; end
            end
            if (!ok) check("w_accept_timeout", 64'(ok), 64'd1);
            @(posedge clk); #1;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;

        if (abort_at >= 0) begin
            rst = 1'b1; s_wvalid = 1'b1; s_wdata = d[nb];
            @(negedge clk);
            check("rst_awready", 64'(s_awready), 64'd0);
            check("rst_wready", 64'(s_wready), 64'd0);
            check("rst_mem_we", 64'(mem_we), 64'd0);
            check("rst_bvalid", 64'(s_bvalid), 64'd0);
            @(posedge clk); #1;
            rst = 1'b0; s_wvalid = 1'b0;
            @(negedge clk);
            check("post_rst_awready", 64'(s_awready), 64'd1);
            check("post_rst_bvalid", 64'(s_bvalid), 64'd0);
        end else begin
            s_bready = 1'b0;
            @(negedge clk);
            check("b_latency", 64'(s_bvalid), 64'd1);
            for (int k = 0; k < bdelay; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("b_hold_valid", 64'(s_bvalid), 64'd1);
                check("b_hold_id", 64'(s_bid), 64'(id));
                check("b_hold_resp", 64'(s_bresp), 64'(eresp));
                check("b_hold_awready", 64'(s_awready), 64'd0);
            end
            @(posedge clk); #1;
            s_bready = 1'b1;
            @(negedge clk);
            check("bvalid", 64'(s_bvalid), 64'd1);
            check("bid", 64'(s_bid), 64'(id));
            check("bresp", 64'(s_bresp), 64'(eresp));
            check("awready_in_b", 64'(s_awready), 64'd0);
            @(posedge clk); #1;
            s_bready = 1'b0;
            @(negedge clk);
            check("awready_after_b", 64'(s_awready), 64'd1);
            check("bvalid_after_b", 64'(s_bvalid), 64'd0);
        end

        check("write_count", 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check("wr_addr", 64'(wr_q[i].a), 64'(exp_q[i].a));
            check("wr_data", wr_q[i].d, exp_q[i].d);
            check("wr_strb", 64'(wr_q[i].s), 64'(exp_q[i].s));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int len;
        int wl;
        rst = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_awready", 64'(s_awready), 64'd0);
        check("reset_wready", 64'(s_wready), 64'd0);
        check("reset_bvalid", 64'(s_bvalid), 64'd0);
        check("reset_bresp", 64'(s_bresp), 64'd0);
        check("reset_bid", 64'(s_bid), 64'd0);
        check("reset_mem_we", 64'(mem_we), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_awready", 64'(s_awready), 64'd1);
        @(posedge clk); #1;
        s_wvalid = 1'b1;
        @(negedge clk);
        check("idle_wready", 64'(s_wready), 64'd0);
        check("idle_mem_we", 64'(mem_we), 64'd0);
        @(posedge clk); #1;
        s_wvalid = 1'b0;

        do_burst(4'h5, 32'h100, 3, 3'd3, 2'b01, 0, 3, -1, 1'b1, 1'b0);
        do_burst(4'h2, 32'h40, 2, 3'd3, 2'b00, 0, 2, -1, 1'b0, 1'b0);
        do_burst(4'h7, 32'h200, 1, 3'd3, 2'b11, 0, 1, -1, 1'b0, 1'b0);
        do_burst(4'h9, 32'h300, 1, 3'd3, 2'b01, 5, 1, -1, 1'b0, 1'b0);
        do_burst(4'h3, 32'h7FF0, 3, 3'd3, 2'b01, 1, 3, -1, 1'b0, 1'b1);
        do_burst(4'h4, 32'h80, 3, 3'd3, 2'b01, 0, 3, 2, 1'b0, 1'b0);
        do_burst(4'h4, 32'h80, 3, 3'd3, 2'b01, 0, 3, -1, 1'b0, 1'b0);
        do_burst(4'h6, 32'h500, 3, 3'd3, 2'b01, 0, 1, -1, 1'b0, 1'b0);
        do_burst(4'h1, 32'h600, 2, 3'd2, 2'b01, 0, 2, -1, 1'b0, 1'b0);
        do_burst(4'h8, 32'h1000, 2, 3'd3, 2'b10, 0, 2, -1, 1'b0, 1'b0);
        do_burst(4'hA, 32'h7F00, 255, 3'd3, 2'b01, 0, 255, -1, 1'b0, 1'b0);

        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(0, 15);
            wl  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : len;
            do_burst(4'($urandom), $urandom,
                     len,
                     ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd3,
                     2'($urandom), $urandom_range(0, 3), wl, -1, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
